// File: rtl/serial_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// serial_alu_seq_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   - default operand width
//   - operation code constants (4-bit op field)
//   - sequencer state encoding
//   - small op classification helpers
// Optional feature macro: SERIAL_SHIFT_EN (adds the SHIFT state for SLL/SRL).
// -----------------------------------------------------------------------------
package serial_alu_seq_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_NE  = 4'd8;
    localparam logic [3:0] OP_LTU = 4'd9;
    localparam logic [3:0] OP_LT  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERIAL = 2'd1,
`ifdef SERIAL_SHIFT_EN
        ST_SHIFT  = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic is_cmp_op(input logic [3:0] op);
        return (op == OP_EQ) || (op == OP_NE) || (op == OP_LTU) || (op == OP_LT);
    endfunction

    // Subtraction and every compare run as A + ~B + 1.
    function automatic logic uses_sub(input logic [3:0] op);
        return (op == OP_SUB) || is_cmp_op(op);
    endfunction

    // Ops that go through the one-bit slice.
    function automatic logic is_serial_op(input logic [3:0] op);
        return (op <= OP_AND) || is_cmp_op(op);
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// -----------------------------------------------------------------------------
// serial_alu_bit
// Combinational one-bit ALU slice used by the serial sequencer.
// Ports:
//   a, b       operand bits for the current position
//   carry_in   carry from the previous (less significant) bit
//   op         operation code (serial_alu_seq_pkg constants)
//   result     result bit for this position
//   carry_out  carry into the next bit (only meaningful for add/sub/compare)
// -----------------------------------------------------------------------------
module serial_alu_bit
    import serial_alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [3:0] op,
    output logic       result,
    output logic       carry_out
);

    logic b_eff;
    logic sum;

    assign b_eff     = uses_sub(op) ? ~b : b;
    assign sum       = a ^ b_eff ^ carry_in;
    assign carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);

    always_comb begin
        result = sum;
        case (op)
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = sum;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// -----------------------------------------------------------------------------
// serial_alu_seq
// Sequencer for the bit-serial execution path. Accepts one operation over a
// valid/ready handshake, runs it LSB-first through serial_alu_bit (or through
// a one-position-per-cycle shifter) and holds the result until consumed.
// Ports:
//   w_clk, w_rst_x            clock, async active-low reset
//   w_req_valid/r_req_ready   request handshake (ready only in IDLE)
//   w_req_op, w_req_a/b       op code and operands
//   r_res_valid/w_res_ready   result handshake
//   r_res_data                result value (0 for compares and illegal ops)
//   r_res_cmp                 compare outcome
//   r_res_err                 unsupported op code
//   r_busy                    sequencer not idle
// Optional feature macro: SERIAL_SHIFT_EN -- builds the SHIFT state for
// SLL/SRL; without it those ops are reported as illegal.
// -----------------------------------------------------------------------------
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            w_clk,
    input  logic            w_rst_x,
    input  logic            w_req_valid,
    output logic            r_req_ready,
    input  logic [3:0]      w_req_op,
    input  logic [XLEN-1:0] w_req_a,
    input  logic [XLEN-1:0] w_req_b,
    output logic            r_res_valid,
    input  logic            w_res_ready,
    output logic [XLEN-1:0] r_res_data,
    output logic            r_res_cmp,
    output logic            r_res_err,
    output logic            r_busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int LAST_BIT_I = XLEN - 1;
    localparam logic [SHW:0] LAST_BIT = LAST_BIT_I[SHW:0];

    state_t          state_q, state_d;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic [SHW:0]    cnt_q;
    logic            carry_q, mism_q, cmp_q, err_q;
    logic            bit_res, bit_cout, bit_diff, last_bit;
    logic            req_is_shift, req_legal;

`ifdef SERIAL_SHIFT_EN
    logic [SHW-1:0]  shamt_q;
    assign req_is_shift = is_shift_op(w_req_op);
`else
    assign req_is_shift = 1'b0;
`endif

    assign req_legal = is_serial_op(w_req_op) || req_is_shift;
    assign last_bit  = (cnt_q == LAST_BIT);
    assign bit_diff  = a_q[0] ^ b_q[0];

    serial_alu_bit u_bit (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .op        (op_q),
        .result    (bit_res),
        .carry_out (bit_cout)
    );

    assign r_req_ready = (state_q == ST_IDLE);
    assign r_res_valid = (state_q == ST_DONE);
    assign r_busy      = (state_q != ST_IDLE);
    assign r_res_data  = res_q;
    assign r_res_cmp   = cmp_q;
    assign r_res_err   = err_q;

    always_ff @(posedge w_clk or negedge w_rst_x) begin
        if (!w_rst_x) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req_valid) begin
                    if (!req_legal) begin
                        state_d = ST_DONE;
                    end
`ifdef SERIAL_SHIFT_EN
                    else if (req_is_shift) begin
                        state_d = ST_SHIFT;
                    end
`endif
                    else begin
                        state_d = ST_SERIAL;
                    end
                end
            end
            ST_SERIAL: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
`ifdef SERIAL_SHIFT_EN
            // Shift amount 0 still spends one cycle here, leaving data = A.
            ST_SHIFT: begin
                if (shamt_q <= 1) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (w_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operands shift right one bit per SERIAL cycle; the slice's
    // result bit enters the MSB so after XLEN cycles res_q holds the answer.
    always_ff @(posedge w_clk or negedge w_rst_x) begin
        if (!w_rst_x) begin
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mism_q  <= 1'b0;
            cmp_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef SERIAL_SHIFT_EN
            shamt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        op_q    <= w_req_op;
                        a_q     <= w_req_a;
                        b_q     <= w_req_b;
                        cnt_q   <= '0;
                        carry_q <= uses_sub(w_req_op);
                        mism_q  <= 1'b0;
                        cmp_q   <= 1'b0;
                        err_q   <= !req_legal;
                        res_q   <= '0;
`ifdef SERIAL_SHIFT_EN
                        if (req_is_shift) begin
                            res_q <= w_req_a;
                        end
                        shamt_q <= w_req_b[SHW-1:0];
`endif
                    end
                end
                ST_SERIAL: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    mism_q  <= mism_q | bit_diff;
                    res_q   <= {bit_res, res_q[XLEN-1:1]};
                    if (last_bit && is_cmp_op(op_q)) begin
                        res_q <= '0;
                        case (op_q)
                            OP_EQ:   cmp_q <= !(mism_q | bit_diff);
                            OP_NE:   cmp_q <= mism_q | bit_diff;
                            OP_LTU:  cmp_q <= !bit_cout;
                            // On the last bit a_q[0]/b_q[0] are the sign bits.
                            default: cmp_q <= bit_diff ? a_q[0] : !bit_cout;
                        endcase
                    end
                end
`ifdef SERIAL_SHIFT_EN
                ST_SHIFT: begin
                    if (shamt_q != 0) begin
                        shamt_q <= shamt_q - 1'b1;
                        if (op_q == OP_SLL) begin
                            res_q <= res_q << 1;
                        end else begin
                            res_q <= res_q >> 1;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_seq
// Directed-vector bench for serial_alu_seq (XLEN = 32). Expected values are
// hand-computed; shift expectations follow SERIAL_SHIFT_EN.
// -----------------------------------------------------------------------------
module tb_serial_alu_seq;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_NE  = 4'd8;
    localparam logic [3:0] OP_LTU = 4'd9;
    localparam logic [3:0] OP_LT  = 4'd10;

    logic            clock;
    logic            rstN;
    logic            reqValid;
    logic            reqReady;
    logic [3:0]      reqOp;
    logic [XLEN-1:0] reqA, reqB;
    logic            resValid;
    logic            resReady;
    logic [XLEN-1:0] resData;
    logic            resCmp;
    logic            resErr;
    logic            busy;

    int vectorCount = 0;
    int missCount   = 0;

    serial_alu_seq #(.XLEN(XLEN)) dut (
        .w_clk       (clock),
        .w_rst_x     (rstN),
        .w_req_valid (reqValid),
        .r_req_ready (reqReady),
        .w_req_op    (reqOp),
        .w_req_a     (reqA),
        .w_req_b     (reqB),
        .r_res_valid (resValid),
        .w_res_ready (resReady),
        .r_res_data  (resData),
        .r_res_cmp   (resCmp),
        .r_res_err   (resErr),
        .r_busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the DUT wedges somewhere unbounded.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one request and waits (bounded) for the result; lat counts
    // rising edges after the accept edge until r_res_valid is seen.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] data, output logic cmp, output logic err,
                                 output int lat);
        @(negedge clock);
        checkOutput("req_ready before issue", {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1;
        reqOp    = op;
        reqA     = a;
        reqB     = b;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        lat = 0;
        while (!resValid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checkOutput("result valid", {31'b0, resValid}, 32'd1);
        data = resData;
        cmp  = resCmp;
        err  = resErr;
        if (resReady) begin
            @(posedge clock);
            #1;
            checkOutput("done one cycle", {30'b0, resValid, reqReady}, 32'd1);
        end
    endtask

    task automatic runVector(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expData, input logic expCmp,
                             input logic expErr, input int expLat);
        logic [31:0] data;
        logic        cmp, err;
        int          lat;
        applyStimulus(op, a, b, data, cmp, err, lat);
        checkOutput({tag, " data"}, data, expData);
        checkOutput({tag, " cmp"}, {31'b0, cmp}, {31'b0, expCmp});
        checkOutput({tag, " err"}, {31'b0, err}, {31'b0, expErr});
        if (expLat >= 0) begin
            checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        end
    endtask

    initial begin
        logic [31:0] data;
        logic        cmp, err;
        int          lat;

        rstN     = 1'b0;
        reqValid = 1'b0;
        reqOp    = 4'd0;
        reqA     = '0;
        reqB     = '0;
        resReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset flags", {27'b0, reqReady, resValid, resCmp, resErr, busy}, 32'h10);
        checkOutput("reset data", resData, 32'h0);
        @(negedge clock);
        rstN = 1'b1;

        runVector("add overflow", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 32);
        runVector("add",          OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 32);
        runVector("sub neg",      OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 32);
        runVector("sub zero",     OP_SUB, 32'h10, 32'h10, 32'h0, 1'b0, 1'b0, 32);
        runVector("xor",          OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b0, 32);
        runVector("or",           OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0, 32);
        runVector("and",          OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 32);
        runVector("ltu 5<7",      OP_LTU, 32'd5, 32'd7, 32'h0, 1'b1, 1'b0, 32);
        runVector("ltu big",      OP_LTU, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b0, 32);
        runVector("lt neg",       OP_LT,  32'h8000_0000, 32'h1, 32'h0, 1'b1, 1'b0, 32);
        runVector("lt pos",       OP_LT,  32'h1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32);
        runVector("lt same sign", OP_LT,  32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 32);
        runVector("eq equal",     OP_EQ,  32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 32);
        runVector("ne equal",     OP_NE,  32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32);
        runVector("eq bit31",     OP_EQ,  32'h9234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32);
        runVector("ne bit0",      OP_NE,  32'h1234_5679, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 32);

`ifdef SERIAL_SHIFT_EN
        runVector("sll 31",       OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 31);
        runVector("srl 4",        OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 4);
        runVector("srl 0",        OP_SRL, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
        runVector("sll b upper",  OP_SLL, 32'h3, 32'h21, 32'h6, 1'b0, 1'b0, 1);
`else
        runVector("sll disabled", OP_SLL, 32'h1, 32'd31, 32'h0, 1'b0, 1'b1, -1);
        runVector("srl disabled", OP_SRL, 32'hDEAD_BEEF, 32'd0, 32'h0, 1'b0, 1'b1, -1);
`endif

        // Illegal op: reported straight away with err set.
        applyStimulus(4'd15, 32'hAAAA_5555, 32'h1, data, cmp, err, lat);
        checkOutput("illegal data", data, 32'h0);
        checkOutput("illegal cmp", {31'b0, cmp}, 32'd0);
        checkOutput("illegal err", {31'b0, err}, 32'd1);
        checkOutput("illegal fast", {31'b0, (lat <= 1)}, 32'd1);
        runVector("after illegal", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 32);

        // Consumer stalls in DONE while a new request is offered.
        resReady = 1'b0;
        applyStimulus(OP_ADD, 32'd2, 32'd3, data, cmp, err, lat);
        checkOutput("stall first data", data, 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            reqValid = 1'b1;
            reqOp    = OP_SUB;
            reqA     = 32'd100;
            reqB     = 32'd1;
            @(posedge clock);
            #1;
            checkOutput("stall data", resData, 32'd5);
            checkOutput("stall flags", {29'b0, resValid, reqReady, busy}, 32'h5);
        end
        @(negedge clock);
        reqValid = 1'b0;
        resReady = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("release idle", {29'b0, resValid, reqReady, busy}, 32'h2);
        runVector("after stall", OP_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 32);

        // Reset in the middle of an ADD aborts it.
        @(negedge clock);
        reqValid = 1'b1;
        reqOp    = OP_ADD;
        reqA     = 32'hFFFF_0000;
        reqB     = 32'h0000_FFFF;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        repeat (16) @(posedge clock);
        #2;
        checkOutput("mid-op busy", {31'b0, busy}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("abort flags", {27'b0, reqReady, resValid, resCmp, resErr, busy}, 32'h10);
        checkOutput("abort data", resData, 32'h0);
        @(negedge clock);
        rstN = 1'b1;
        runVector("after reset", OP_ADD, 32'd7, 32'd8, 32'hF, 1'b0, 1'b0, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
